// File: rtl/wb_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter_2
// Brief    : Two-master, one-slave Wishbone classic arbiter. The grant is held
//            for a whole CYC, and priority alternates round-robin between the
//            masters. A bus watchdog forces ERR back to the owning master when
//            the slave leaves a strobe unanswered for TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter_2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,

  // master 0
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  output logic                    m0_gnt_o,

  // master 1
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic                    m1_gnt_o,

  // slave
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,

  output logic                    timeout_o
);

  // IDLE: nobody owns the slave; G0/G1: master 0/1 owns it for its whole CYC.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state;
  logic   last;      // master that most recently released the bus
  logic   tmo_err;   // one-cycle watchdog error pulse
  logic   slave_resp;

  assign slave_resp = s_ack_i | s_err_i | s_rty_i;

  // Grant FSM: one-cycle arbitration from IDLE, back-to-back handover on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state <= last ? G0 : G1;
          end else if (m0_cyc_i) begin
            state <= G0;
          end else if (m1_cyc_i) begin
            state <= G1;
          end
        end
        G0: begin
          if (!m0_cyc_i) begin
            last  <= 1'b0;
            state <= m1_cyc_i ? G1 : IDLE;
          end
        end
        G1: begin
          if (!m1_cyc_i) begin
            last  <= 1'b1;
            state <= m0_cyc_i ? G0 : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt_o = (state == G0);
  assign m1_gnt_o = (state == G1);

  // Read data fans out to both masters unconditionally; only ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Slave-side mux: owner's request passes through, everything else is zero.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (state)
      G0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~tmo_err;
      end
      G1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~tmo_err;
      end
      default: begin
      end
    endcase
  end

  // Response routing: only the owner sees responses; a watchdog error masks
  // any slave ack/rty arriving in the same cycle.
  always_comb begin
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (state == G0) begin
      m0_ack_o = s_ack_i & ~tmo_err;
      m0_rty_o = s_rty_i & ~tmo_err;
      m0_err_o = s_err_i | tmo_err;
    end else if (state == G1) begin
      m1_ack_o = s_ack_i & ~tmo_err;
      m1_rty_o = s_rty_i & ~tmo_err;
      m1_err_o = s_err_i | tmo_err;
    end
  end

  assign timeout_o = tmo_err;

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

      logic [15:0] tmo_cnt;
      logic        tmo_busy;

      // A grant change always passes through a cycle where the owner's CYC is
      // low (s_cyc_o = 0), so the idle clear below also covers handovers.
      assign tmo_busy = s_cyc_o & s_stb_o & ~slave_resp;

      // Count unanswered strobe cycles; fire a single ERR pulse at the limit.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tmo_cnt <= 16'd0;
          tmo_err <= 1'b0;
        end else begin
          tmo_err <= 1'b0;
          if (tmo_busy) begin
            if (tmo_cnt == TMO_LAST) begin
              tmo_err <= 1'b1;
              tmo_cnt <= 16'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end else begin
            tmo_cnt <= 16'd0;
          end
        end
      end
    end else begin : g_no_watchdog
      assign tmo_err = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_arbiter_2
// Brief    : Directed self-checking bench for wb_rr_arbiter_2 (TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter_2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m0_dat_o;
  logic        m0_we_i = 1'b0, m0_stb_i = 1'b0, m0_cyc_i = 1'b0;
  logic [3:0]  m0_sel_i = '0;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m0_gnt_o;

  logic [31:0] m1_adr_i = '0, m1_dat_i = '0, m1_dat_o;
  logic        m1_we_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0;
  logic [3:0]  m1_sel_i = '0;
  logic        m1_ack_o, m1_err_o, m1_rty_o, m1_gnt_o;

  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = '0;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic        timeout_o;

  int checks   = 0;
  int failures = 0;

  wb_rr_arbiter_2 #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .SELECT_WIDTH(4),
    .TIMEOUT     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_dat_o (m0_dat_o),
    .m0_we_i  (m0_we_i),
    .m0_sel_i (m0_sel_i),
    .m0_stb_i (m0_stb_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m0_rty_o (m0_rty_o),
    .m0_gnt_o (m0_gnt_o),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_dat_o (m1_dat_o),
    .m1_we_i  (m1_we_i),
    .m1_sel_i (m1_sel_i),
    .m1_stb_i (m1_stb_i),
    .m1_cyc_i (m1_cyc_i),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .m1_rty_o (m1_rty_o),
    .m1_gnt_o (m1_gnt_o),
    .s_adr_o  (s_adr_o),
    .s_dat_i  (s_dat_i),
    .s_dat_o  (s_dat_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    #1;
    check("rst_gnt0", m0_gnt_o, 0);
    check("rst_gnt1", m1_gnt_o, 0);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_tmo", timeout_o, 0);
    rst = 1'b1;

    // ---------------- 1: single master write ----------------
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
    m0_adr_i = 32'h10; m0_dat_i = 32'hDEADBEEF;
    #1;
    check("t1_nogrant_yet", m0_gnt_o, 0);
    check("t1_idle_adr", s_adr_o, 0);
    tick();                                   // grant cycle
    check("t1_gnt", m0_gnt_o, 1);
    check("t1_adr", s_adr_o, 32'h10);
    check("t1_dat", s_dat_o, 32'hDEADBEEF);
    check("t1_we", s_we_o, 1);
    check("t1_sel", s_sel_o, 4'hF);
    check("t1_stb", s_stb_o, 1);
    s_rty_i = 1;
    #1;
    check("t1_rty", m0_rty_o, 1);
    check("t1_rty_other", m1_rty_o, 0);
    tick();
    s_rty_i = 0; s_ack_i = 1;
    #1;
    check("t1_ack", m0_ack_o, 1);
    check("t1_ack_other", m1_ack_o, 0);
    tick();
    s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    check("t1_cyc_drop", s_cyc_o, 0);
    tick();
    check("t1_idle", m0_gnt_o, 0);
    check("t1_idle_adr2", s_adr_o, 0);
    check("t1_idle_dat", s_dat_o, 0);

    // ---------------- 2: contention + round robin ----------------
    apply_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick();
    check("t2_first_m0", m0_gnt_o, 1);
    check("t2_first_m1", m1_gnt_o, 0);
    tick();
    m0_cyc_i = 0;                             // cycle k
    #1;
    check("t2_k_still_g0", m0_gnt_o, 1);
    tick();                                   // k+1
    check("t2_handover_m1", m1_gnt_o, 1);
    check("t2_handover_m0", m0_gnt_o, 0);
    check("t2_handover_cyc", s_cyc_o, 1);

    // ---------------- 3: lock while m0 requests ----------------
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hAAAA0000;
    m1_stb_i = 1; m1_adr_i = 32'h00000200;
    for (int i = 0; i < 3; i++) begin
      s_ack_i = 1;
      #1;
      check("t3_m1_ack", m1_ack_o, 1);
      check("t3_m0_ack", m0_ack_o, 0);
      check("t3_m0_gnt", m0_gnt_o, 0);
      check("t3_adr", s_adr_o, 32'h200);
      tick();
      s_ack_i = 0;
      #1;
      check("t3_m0_gnt_b", m0_gnt_o, 0);
      tick();
    end
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    check("t3_m0_after", m0_gnt_o, 1);
    check("t3_adr_m0", s_adr_o, 32'hAAAA0000);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();                                   // IDLE, last = 0
    check("t3_idle", m0_gnt_o | m1_gnt_o, 0);
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick();
    check("t2_rr_m1", m1_gnt_o, 1);
    check("t2_rr_m0", m0_gnt_o, 0);
    m1_cyc_i = 0;
    tick();
    check("t2_rr_back_m0", m0_gnt_o, 1);
    m0_cyc_i = 0;
    tick();
    check("t2_rr_idle", m0_gnt_o, 0);

    // ---------------- 4: watchdog ----------------
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h40;
    tick();                                   // cycle 0: first STB on slave
    check("t4_stb0", s_stb_o, 1);
    for (int c = 1; c < 8; c++) begin
      tick();
      check("t4_no_tmo", timeout_o, 0);
      check("t4_no_err", m0_err_o, 0);
    end
    tick();                                   // cycle 8
    s_ack_i = 1;                              // late response collides
    #1;
    check("t4_tmo", timeout_o, 1);
    check("t4_err", m0_err_o, 1);
    check("t4_stb_mask", s_stb_o, 0);
    check("t4_ack_drop", m0_ack_o, 0);
    check("t4_err_other", m1_err_o, 0);
    tick();
    s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    check("t4_pulse", timeout_o, 0);
    tick();                                   // IDLE
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();                                   // cycle 0
    for (int c = 1; c < 7; c++) tick();
    tick();                                   // cycle 7
    s_ack_i = 1;
    #1;
    check("t4b_ack7", m0_ack_o, 1);
    check("t4b_err7", m0_err_o, 0);
    tick();                                   // cycle 8
    s_ack_i = 0;
    #1;
    check("t4b_no_tmo", timeout_o, 0);
    check("t4b_no_err", m0_err_o, 0);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // ---------------- 5: reset mid-cycle ----------------
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h80;
    tick();
    check("t5_g1", m1_gnt_o, 1);
    check("t5_stb_pre", s_stb_o, 1);
    rst = 1'b0;
    #1;
    check("t5_cyc", s_cyc_o, 0);
    check("t5_stb", s_stb_o, 0);
    check("t5_gnt", m1_gnt_o, 0);
    tick();
    m0_cyc_i = 1;
    rst = 1'b1;
    tick();
    check("t5_m0_wins", m0_gnt_o, 1);
    check("t5_m1_loses", m1_gnt_o, 0);

    // ---------------- 6: read data ----------------
    m0_cyc_i = 0;
    tick();                                   // direct handover to m1
    check("t6_g1", m1_gnt_o, 1);
    s_dat_i = 32'h12345678; s_ack_i = 1;
    #1;
    check("t6_dat", m1_dat_o, 32'h12345678);
    check("t6_dat_m0", m0_dat_o, 32'h12345678);
    check("t6_ack", m1_ack_o, 1);
    check("t6_ack_m0", m0_ack_o, 0);
    check("t6_we", s_we_o, 0);
    tick();
    s_ack_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();                                   // IDLE
    s_ack_i = 1; s_err_i = 1;
    #1;
    check("idle_ack_m0", m0_ack_o, 0);
    check("idle_ack_m1", m1_ack_o, 0);
    check("idle_err_m1", m1_err_o, 0);
    s_ack_i = 0; s_err_i = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=0x%08h exp=0x%08h", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
